// File: rtl/mul_div_unit_pkg.sv
// Shared types, encodings and helpers for the multi-cycle HI/LO multiply/divide unit.
package mul_div_unit_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DLEN  = 64;
    localparam int unsigned MC_W  = 4;
    localparam int unsigned CNT_W = 5;

    // One-hot operation select from the decoder.
    localparam logic [MC_W-1:0] MULT_MC  = 4'b0001;
    localparam logic [MC_W-1:0] MULTU_MC = 4'b0010;
    localparam logic [MC_W-1:0] DIV_MC   = 4'b0100;
    localparam logic [MC_W-1:0] DIVU_MC  = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // Per-operation context captured on accept and consumed in FIX.
    typedef struct packed {
        logic            is_div;
        logic            neg_res;   // product / quotient must be negated
        logic            neg_rem;   // remainder takes the dividend's sign
        logic            div0;      // divisor was zero
        logic [XLEN-1:0] a_raw;     // original dividend, for the divide-by-zero result
    } op_ctx_t;

    function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] x);
        return ~x + XLEN'(1);
    endfunction

    function automatic logic [DLEN-1:0] neg64(input logic [DLEN-1:0] x);
        return ~x + DLEN'(1);
    endfunction

    function automatic logic [XLEN-1:0] abs32(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? neg32(x) : x;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request / HI-LO bus between the pipeline (master) and the multiply/divide unit (slave).
interface mul_div_unit_if;
    import mul_div_unit_pkg::*;

    logic [MC_W-1:0] mul_control;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            hi_wen;
    logic            lo_wen;
    logic [XLEN-1:0] wdata;
    logic            busy;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output mul_control, req_valid, src_a, src_b, flush, hi_wen, lo_wen, wdata,
        input  req_ready, busy, hi, lo
    );

    modport slave (
        input  mul_control, req_valid, src_a, src_b, flush, hi_wen, lo_wen, wdata,
        output req_ready, busy, hi, lo
    );
endinterface

// File: rtl/mul_div_unit_step.sv
// One iteration of radix-2 shift-add multiply or restoring divide on a 64-bit accumulator.
// Multiply: acc = {partial product high, remaining multiplier bits}, shifts right.
// Divide:   acc = {partial remainder, remaining dividend / quotient bits}, shifts left.
module mul_div_step
    import mul_div_unit_pkg::*;
(
    input  logic            is_div,
    input  logic [XLEN-1:0] opnd,
    input  logic [DLEN-1:0] acc,
    output logic [DLEN-1:0] acc_next_c
);

    logic [XLEN:0]   add_sum;
    logic            rem_ge;
    logic [XLEN-1:0] rem_diff;

    // Single combinational step; the 33-bit compare covers the bit shifted out of the remainder.
    always_comb begin
        add_sum    = {1'b0, acc[DLEN-1:XLEN]} + {1'b0, opnd};
        rem_ge     = (acc[DLEN-1:XLEN-1] >= {1'b0, opnd});
        rem_diff   = acc[DLEN-2:XLEN-1] - opnd;
        acc_next_c = '0;
        if (is_div) begin
            if (rem_ge) begin
                acc_next_c = {rem_diff, acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next_c = {acc[DLEN-2:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                acc_next_c = {add_sum, acc[XLEN-1:1]};
            end else begin
                acc_next_c = {1'b0, acc[DLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: 32 iteration cycles plus one sign-fix cycle.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mul_div_unit_if.slave bus
);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    op_ctx_t         ctx_q, ctx_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            busy_q, busy_d;

    logic [DLEN-1:0] step_acc_c;
    logic            accept_c;
    logic            mtxx_c;
    logic            is_signed_c;
    logic            is_div_c;
    logic            neg_a_c;
    logic            neg_b_c;
    logic [XLEN-1:0] mag_a_c;
    logic [XLEN-1:0] mag_b_c;
    logic [DLEN-1:0] prod_c;

    mul_div_step u_step (
        .is_div     (ctx_q.is_div),
        .opnd       (opnd_q),
        .acc        (acc_q),
        .acc_next_c (step_acc_c)
    );

    assign bus.req_ready = (state_q == ST_IDLE) && !bus.flush;
    assign bus.busy      = busy_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

    // Next-state, datapath and HI/LO write selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        ctx_d   = ctx_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        accept_c    = (state_q == ST_IDLE) && !bus.flush && bus.req_valid &&
                      (bus.mul_control != '0);
        mtxx_c      = bus.hi_wen || bus.lo_wen;
        is_signed_c = |(bus.mul_control & (MULT_MC | DIV_MC));
        is_div_c    = |(bus.mul_control & (DIV_MC | DIVU_MC));
        neg_a_c     = is_signed_c && bus.src_a[XLEN-1];
        neg_b_c     = is_signed_c && bus.src_b[XLEN-1];
        mag_a_c     = is_signed_c ? abs32(bus.src_a) : bus.src_a;
        mag_b_c     = is_signed_c ? abs32(bus.src_b) : bus.src_b;
        prod_c      = ctx_q.neg_res ? neg64(acc_q) : acc_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d       = ST_CALC;
                    cnt_d         = '0;
                    acc_d         = {XLEN'(0), (is_div_c ? mag_a_c : mag_b_c)};
                    opnd_d        = is_div_c ? mag_b_c : mag_a_c;
                    ctx_d.is_div  = is_div_c;
                    ctx_d.neg_res = neg_a_c ^ neg_b_c;
                    ctx_d.neg_rem = neg_a_c;
                    ctx_d.div0    = is_div_c && (bus.src_b == '0);
                    ctx_d.a_raw   = bus.src_a;
                end
            end
            ST_CALC: begin
                acc_d = step_acc_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == '1) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!ctx_q.is_div) begin
                    hi_d = prod_c[DLEN-1:XLEN];
                    lo_d = prod_c[XLEN-1:0];
                end else if (ctx_q.div0) begin
                    hi_d = ctx_q.a_raw;
                    lo_d = '1;
                end else begin
                    lo_d = ctx_q.neg_res ? neg32(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
                    hi_d = ctx_q.neg_rem ? neg32(acc_q[DLEN-1:XLEN]) : acc_q[DLEN-1:XLEN];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush or an mthi/mtlo while busy cancels the operation, including its FIX write.
        if ((state_q != ST_IDLE) && (mtxx_c || bus.flush)) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end

        if (bus.hi_wen) begin
            hi_d = bus.wdata;
        end
        if (bus.lo_wen) begin
            lo_d = bus.wdata;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            ctx_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            ctx_q   <= ctx_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

endmodule
